merge_seq_ctrl: RTL and testbench
=================================

Name: merge_seq_ctrl

Overview:
- Sequencer for the sprite/background merge datapath.
- Walks the visible frame in 16-pixel words and issues background and sprite ROM addresses each cycle.
- Emits per-pixel slot index and write strobe to the merge stage, and owns the A/B ping-pong bank selector (readVgaSelector) with a swap handshake to the VGA reader.
- Sits between the frame timing/game logic and the merge block.

Parameters:
- H_RES, 640, visible pixels per line (multiple of PIX_PER_WORD)
- V_RES, 480, visible lines per frame
- PIX_PER_WORD, 16, pixels per 128-bit bank word (slot counter 4 bits)
- SPRITE_SIZE, 16, sprite edge in pixels
- BG_AW, 19, background ROM address width (H_RES*V_RES must fit)
- SP_AW, 8, sprite ROM address width (SPRITE_SIZE^2 must fit)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a frame from IDLE; ignored otherwise
- sprite_x  in  10  sprite left column, sampled at frame start
- sprite_y  in  10  sprite top line, sampled at frame start
- vga_done  in  1  one-cycle pulse: VGA finished consuming its current bank
- bg_addr  out  BG_AW  background ROM address
- sp_addr  out  SP_AW  sprite ROM address (0 outside window)
- sp_in_win  out  1  pixel at bg_addr lies inside the sprite window
- pix_valid  out  1  merge write strobe, aligned with ROM data (one cycle after address)
- pix_slot  out  4  slot index in the bank word for pix_valid
- readVgaSelector  out  1  1: VGA reads B, merge writes A; 0: the opposite
- bank_full  out  1  write bank holds 16 merged pixels, waiting to swap
- frame_done  out  1  one-cycle pulse after the last word of the frame is swapped
- busy  out  1  state != IDLE
- underrun  out  1  sticky: a vga_done arrived while one was already pending

Behaviour:
- Reset values: all outputs 0 except readVgaSelector=1. Counters are 0, pending=0, and the VGA read bank is marked empty.
- States:
  - IDLE: wait for start. On start, latch sprite_x/sprite_y into shadow registers, clear x/y/slot, go to FILL.
  - FILL: issue one address per cycle with slot 0..15. After slot 15 is issued, go to DRAIN (1 cycle, last pix_valid).
  - DRAIN: then go to WAIT_SWAP.
  - WAIT_SWAP: bank_full=1. Swap when pending=1 or the read bank is empty.
- Swap cycle:
  - Toggle readVgaSelector, clear pending, clear bank_full, mark the read bank full.
  - Advance x by 16. At x==H_RES, x wraps to 0 and y increments.
  - If y was V_RES-1 and x wrapped, pulse frame_done and go to IDLE. Otherwise go to FILL.
- Latency: pix_valid/pix_slot are the registered copies of issue-valid/slot, exactly 1 cycle after bg_addr/sp_addr.
- Fill rate: one word takes 17 cycles from FILL entry to WAIT_SWAP.
- Address arithmetic:
  - bg_addr = y*H_RES + x + slot, computed at BG_AW bits.
  - In-window test uses 11-bit compares: px>=sx && px<sx+SPRITE_SIZE, and the same for y. This means no wrap at screen edge.
  - sp_addr = (y-sy)*SPRITE_SIZE + (px-sx) when in window, else 0.
- vga_done handling:
  - Sets pending in any state, including FILL and DRAIN.
  - If pending is already 1, underrun is set and stays set until reset.
- Simultaneous vga_done and swap in WAIT_SWAP: the swap consumes the pulse; pending ends at 0.
- start while busy: ignored. Sprite shadow registers do not change mid-frame.
- Reset asserted mid-frame: immediate return to reset values. Any partially filled bank is abandoned.

Optional Feature:
- Macro MERGE_SEQ_CONT_EN.
- Defined: after the final swap, frame_done pulses and the FSM goes straight back to FILL for a new frame. The sprite shadow registers re-sample in the same cycle, and start is ignored.
- Undefined: the FSM returns to IDLE and waits for start.

Decomposition:
- Shared package merge_pkg:
  - state enum (IDLE, FILL, DRAIN, WAIT_SWAP)
  - H_RES/V_RES/PIX_PER_WORD/SPRITE_SIZE defaults
  - transparent-colour constant 8'h17 shared with the merge stage
- One sub-module, sprite_win_addr: registered window test and sp_addr generation from (px, py, sx, sy).

Test Plan:
- Reset released, start pulse, no vga_done: first word fills slots 0..15 with bg_addr 0..15, then swaps immediately. readVgaSelector goes 1→0 at cycle 18, then bank_full holds at 1 with bg_addr issue stopped.
- sprite_x=8, sprite_y=0: pixels 8..15 of word 0 have sp_in_win=1 and sp_addr 0..7, pixels 0..7 have sp_in_win=0 and sp_addr=0. Word 1 pixels 0..7 give sp_addr 8..15.
- vga_done pulsed during FILL of word 1: the swap happens on the first WAIT_SWAP cycle and pending clears. A second vga_done before that swap sets underrun=1, which stays set.
- Full 640x480 frame with vga_done issued on each bank_full: exactly 19200 swaps and a single frame_done pulse after the last one. With the macro defined, FILL restarts at bg_addr 0; without it, busy=0.
- reset asserted at slot 7 of word 3: all outputs return to reset values the same cycle with readVgaSelector=1. After the next start, fill begins at bg_addr 0.
- sprite_x=630 (window crosses the right edge): pixels 630..639 are in-window, and pixel 0 of the next line is not in-window (no wrap).

Source files
------------

// File: rtl/merge_seq_ctrl_pkg.sv
// rtl/merge_seq_ctrl_pkg.sv - shared state type, geometry defaults and colour key for the merge sequencer
// Contents: seq_state_t (IDLE, FILL, DRAIN, WAIT_SWAP), frame/word/sprite geometry defaults,
//           TRANSPARENT_COLOR (colour key also used by the merge stage).
package merge_pkg;

  localparam int H_RES_DEF        = 640;
  localparam int V_RES_DEF        = 480;
  localparam int PIX_PER_WORD_DEF = 16;
  localparam int SPRITE_SIZE_DEF  = 16;

  localparam logic [7:0] TRANSPARENT_COLOR = 8'h17;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    WAIT_SWAP
  } seq_state_t;

endpackage

// File: rtl/merge_seq_ctrl_sprite_win_addr.sv
// rtl/merge_seq_ctrl_sprite_win_addr.sv - registered sprite window test and sprite ROM address
// Ports:
//   clk, reset (async, active-low)
//   en            : load a new result this cycle (hold otherwise, so outputs stay aligned with bg_addr)
//   px, py        : pixel column / line being issued
//   sx, sy        : sprite top-left corner
//   in_win        : registered, pixel lies inside the sprite window
//   addr          : registered sprite ROM address, 0 outside the window
module sprite_win_addr
  import merge_pkg::*;
#(
  parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
  parameter int SP_AW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [9:0]       px,
  input  logic [9:0]       py,
  input  logic [9:0]       sx,
  input  logic [9:0]       sy,
  output logic             in_win,
  output logic [SP_AW-1:0] addr
);

  logic [10:0]      px_w, py_w, sx_w, sy_w;
  logic             hit;
  logic [SP_AW-1:0] addr_c;

  // 11-bit compares: a window hanging past the right/bottom edge never wraps to column/line 0.
  always_comb begin
    px_w   = {1'b0, px};
    py_w   = {1'b0, py};
    sx_w   = {1'b0, sx};
    sy_w   = {1'b0, sy};
    hit    = (px_w >= sx_w) && (px_w < sx_w + 11'(SPRITE_SIZE)) &&
             (py_w >= sy_w) && (py_w < sy_w + 11'(SPRITE_SIZE));
    addr_c = SP_AW'(py_w - sy_w) * SP_AW'(SPRITE_SIZE) + SP_AW'(px_w - sx_w);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_win <= 1'b0;
      addr   <= '0;
    end else if (en) begin
      in_win <= hit;
      addr   <= hit ? addr_c : '0;
    end
  end

endmodule

// File: rtl/merge_seq_ctrl.sv
// rtl/merge_seq_ctrl.sv - frame walker and A/B bank sequencer for the sprite/background merge
// Optional build macro: MERGE_SEQ_CONT_EN (continuous frames, start ignored after the first frame).
// Ports:
//   clk, reset (async, active-low)
//   start            : pulse, begins a frame from IDLE
//   sprite_x/y       : sprite corner, latched at frame start
//   vga_done         : pulse, VGA finished its current bank
//   bg_addr/sp_addr  : background / sprite ROM addresses, sp_in_win marks window pixels
//   pix_valid/slot   : merge write strobe and slot, one cycle after the addresses
//   readVgaSelector  : 1 = VGA reads B, merge writes A
//   bank_full        : write bank complete, waiting for a swap
//   frame_done       : pulse after the last word of the frame is swapped
//   busy, underrun   : not idle / sticky double vga_done
module merge_seq_ctrl
  import merge_pkg::*;
#(
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
  parameter int SPRITE_SIZE  = SPRITE_SIZE_DEF,
  parameter int BG_AW        = 19,
  parameter int SP_AW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [9:0]       sprite_x,
  input  logic [9:0]       sprite_y,
  input  logic             vga_done,
  output logic [BG_AW-1:0] bg_addr,
  output logic [SP_AW-1:0] sp_addr,
  output logic             sp_in_win,
  output logic             pix_valid,
  output logic [3:0]       pix_slot,
  output logic             readVgaSelector,
  output logic             bank_full,
  output logic             frame_done,
  output logic             busy,
  output logic             underrun
);

  localparam logic [3:0] LAST_SLOT = 4'(PIX_PER_WORD - 1);

  seq_state_t state;
  logic [9:0] x, y, sx_q, sy_q, px;
  logic [3:0] slot, iss_slot;
  logic       iss_vld, pending, rd_full;
  logic       issue, swap, last_col, last_row;

  assign issue    = (state == FILL);
  // A swap needs the VGA side free: either it reported done, or it has never been given a bank.
  assign swap     = (state == WAIT_SWAP) && (pending || !rd_full);
  assign last_col = (x == 10'(H_RES - PIX_PER_WORD));
  assign last_row = (y == 10'(V_RES - 1));
  assign px       = x + 10'(slot);

  sprite_win_addr #(
    .SPRITE_SIZE(SPRITE_SIZE),
    .SP_AW      (SP_AW)
  ) u_win (
    .clk   (clk),
    .reset (reset),
    .en    (issue),
    .px    (px),
    .py    (y),
    .sx    (sx_q),
    .sy    (sy_q),
    .in_win(sp_in_win),
    .addr  (sp_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      x               <= '0;
      y               <= '0;
      slot            <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      iss_vld         <= 1'b0;
      iss_slot        <= '0;
      bg_addr         <= '0;
      pix_valid       <= 1'b0;
      pix_slot        <= '0;
      readVgaSelector <= 1'b1;
      bank_full       <= 1'b0;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
      underrun        <= 1'b0;
      pending         <= 1'b0;
      rd_full         <= 1'b0;
    end else begin
      // Address stage registers, then the strobe stage one cycle later (ROM read latency).
      iss_vld    <= issue;
      pix_valid  <= iss_vld;
      pix_slot   <= iss_slot;
      frame_done <= 1'b0;
      if (issue) begin
        bg_addr  <= BG_AW'(y) * BG_AW'(H_RES) + BG_AW'(px);
        iss_slot <= slot;
      end

      // A swap consumes any vga_done arriving in the same cycle.
      if (vga_done && pending) underrun <= 1'b1;
      pending <= swap ? 1'b0 : (pending | vga_done);

      case (state)
        IDLE: begin
          if (start) begin
            sx_q  <= sprite_x;
            sy_q  <= sprite_y;
            x     <= '0;
            y     <= '0;
            slot  <= '0;
            busy  <= 1'b1;
            state <= FILL;
          end
        end
        FILL: begin
          slot <= slot + 4'd1;
          if (slot == LAST_SLOT) begin
            slot  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          bank_full <= 1'b1;
          state     <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (swap) begin
            readVgaSelector <= ~readVgaSelector;
            bank_full       <= 1'b0;
            rd_full         <= 1'b1;
            if (last_col) begin
              x <= '0;
              if (last_row) begin
                y          <= '0;
                frame_done <= 1'b1;
`ifdef MERGE_SEQ_CONT_EN
                sx_q  <= sprite_x;
                sy_q  <= sprite_y;
                state <= FILL;
`else
                busy  <= 1'b0;
                state <= IDLE;
`endif
              end else begin
                y     <= y + 10'd1;
                state <= FILL;
              end
            end else begin
              x     <= x + 10'(PIX_PER_WORD);
              state <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_seq_ctrl.sv
// tb/tb_merge_seq_ctrl.sv - self-checking bench for merge_seq_ctrl
module tb_merge_seq_ctrl;

  localparam int H     = 640;
  localparam int V     = 8;
  localparam int PPW   = 16;
  localparam int SS    = 16;
  localparam int BGW   = 19;
  localparam int SPW   = 8;
  localparam int WORDS = H * V / PPW;

  logic clk = 1'b0;
  logic reset, start, man_done, auto_done, vga_done;
  logic [9:0] sprite_x, sprite_y;
  logic [BGW-1:0] bg_addr;
  logic [SPW-1:0] sp_addr;
  logic sp_in_win, pix_valid, readVgaSelector, bank_full, frame_done, busy, underrun;
  logic [3:0] pix_slot;

  assign vga_done = man_done | auto_done;

  always #5 clk = ~clk;

  merge_seq_ctrl #(
    .H_RES(H), .V_RES(V), .PIX_PER_WORD(PPW), .SPRITE_SIZE(SS), .BG_AW(BGW), .SP_AW(SPW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .vga_done(vga_done), .bg_addr(bg_addr), .sp_addr(sp_addr), .sp_in_win(sp_in_win),
    .pix_valid(pix_valid), .pix_slot(pix_slot), .readVgaSelector(readVgaSelector),
    .bank_full(bank_full), .frame_done(frame_done), .busy(busy), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame model: the n-th strobed pixel of a frame is pixel n in raster order.
  int sx_m, sy_m;
  int n_pix, pix_total, swaps, fd_count;
  int prev_bg, prev_win, prev_sp;
  int m_px, m_py, m_win, m_sp;
  int cap_win[1024];
  int cap_sp[1024];
  logic prev_sel;

  always @(negedge clk) begin
    if (!reset) begin
      n_pix = 0; pix_total = 0; swaps = 0; fd_count = 0; prev_sel = 1'b1;
      for (int i = 0; i < 1024; i++) begin cap_win[i] = -1; cap_sp[i] = -1; end
    end else begin
      if (pix_valid) begin
        m_px  = n_pix % H;
        m_py  = n_pix / H;
        m_win = (m_px >= sx_m && m_px < sx_m + SS && m_py >= sy_m && m_py < sy_m + SS) ? 1 : 0;
        m_sp  = (m_win == 1) ? (m_py - sy_m) * SS + (m_px - sx_m) : 0;
        chk("bg_addr", prev_bg, n_pix);
        chk("pix_slot", int'(pix_slot), n_pix % PPW);
        chk("sp_in_win", prev_win, m_win);
        chk("sp_addr", prev_sp, m_sp);
        if (n_pix < 1024) begin cap_win[n_pix] = prev_win; cap_sp[n_pix] = prev_sp; end
        n_pix = (n_pix + 1) % (H * V);
        pix_total++;
      end
      if (readVgaSelector != prev_sel) swaps++;
      prev_sel = readVgaSelector;
      if (frame_done) fd_count++;
    end
    prev_bg  = int'(bg_addr);
    prev_win = int'(sp_in_win);
    prev_sp  = int'(sp_addr);
  end

  // VGA stand-in: one vga_done per bank_full episode.
  logic auto_en = 1'b0;
  logic acked = 1'b0;
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (!bank_full) acked = 1'b0;
    else if (auto_en && !acked) begin auto_done = 1'b1; acked = 1'b1; end
  end

  int e;
  task automatic nedge();
    @(negedge clk);
    e++;
  endtask
  task automatic wait_e(input int t);
    while (e < t) nedge();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bg_addr"}, int'(bg_addr), 0);
    chk({tag, "_sp_addr"}, int'(sp_addr), 0);
    chk({tag, "_sp_in_win"}, int'(sp_in_win), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_slot"}, int'(pix_slot), 0);
    chk({tag, "_sel"}, int'(readVgaSelector), 1);
    chk({tag, "_bank_full"}, int'(bank_full), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_underrun"}, int'(underrun), 0);
  endtask

  int guard;
  logic seen;

  initial begin
    reset = 1'b0; start = 1'b0; man_done = 1'b0;
    sprite_x = '0; sprite_y = '0; sx_m = 0; sy_m = 0; e = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // Word 0 swaps at once (read bank empty); word 1 swaps on pending; word 2 stalls.
    sprite_x = 10'd8; sprite_y = 10'd0; sx_m = 8; sy_m = 0;
    start = 1'b1; e = -1;
    nedge();
    start = 1'b0;
    wait_e(17);
    chk("w0_sel_before_swap", int'(readVgaSelector), 1);
    chk("w0_bank_full", int'(bank_full), 1);
    chk("w0_busy", int'(busy), 1);
    wait_e(18);
    chk("w0_sel_after_swap", int'(readVgaSelector), 0);
    chk("w0_bank_full_clr", int'(bank_full), 0);
    wait_e(24); man_done = 1'b1;
    wait_e(25); man_done = 1'b0;
    wait_e(35);
    chk("w1_bank_full", int'(bank_full), 1);
    chk("w1_sel_wait", int'(readVgaSelector), 0);
    wait_e(36);
    chk("w1_sel_swap", int'(readVgaSelector), 1);
    chk("w1_bank_full_clr", int'(bank_full), 0);
    chk("w1_underrun", int'(underrun), 0);
    wait_e(60);
    chk("w2_stall_bank_full", int'(bank_full), 1);
    chk("w2_stall_sel", int'(readVgaSelector), 1);
    chk("w2_stall_pix_valid", int'(pix_valid), 0);
    chk("w2_stall_bg_addr", int'(bg_addr), 47);
    man_done = 1'b1;
    wait_e(61); man_done = 1'b0;
    chk("w2_sel_pending", int'(readVgaSelector), 1);
    wait_e(62);
    chk("w2_sel_swap", int'(readVgaSelector), 0);
    wait_e(64); man_done = 1'b1;
    wait_e(65); man_done = 1'b0;
    chk("w3_no_underrun", int'(underrun), 0);
    wait_e(66); man_done = 1'b1;
    wait_e(67); man_done = 1'b0;
    chk("w3_underrun_set", int'(underrun), 1);
    wait_e(69);
    chk("w3_underrun_sticky", int'(underrun), 1);
    chk("w3_bg_addr_slot6", int'(bg_addr), 54);
    chk("w3_pix_slot5", int'(pix_slot), 5);
    chk("a_win_px0", cap_win[0], 0);
    chk("a_sp_px0", cap_sp[0], 0);
    chk("a_win_px7", cap_win[7], 0);
    chk("a_win_px8", cap_win[8], 1);
    chk("a_sp_px8", cap_sp[8], 0);
    chk("a_sp_px15", cap_sp[15], 7);
    chk("a_sp_px16", cap_sp[16], 8);
    chk("a_sp_px23", cap_sp[23], 15);
    chk("a_win_px24", cap_win[24], 0);

    // Mid-frame reset while slot 7 of word 3 is being issued.
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Window crossing the right edge; full frame with VGA acking every bank.
    sprite_x = 10'd630; sprite_y = 10'd0; sx_m = 630; sy_m = 0;
    start = 1'b1; e = -1;
    nedge();
    start = 1'b0;
    wait_e(1);
    chk("b_first_bg_addr", int'(bg_addr), 0);
    chk("b_first_win", int'(sp_in_win), 0);
    chk("b_busy", int'(busy), 1);
    wait_e(5);
    sprite_x = 10'd0; start = 1'b1;
    wait_e(6);
    start = 1'b0; sprite_x = 10'd630;
    auto_en = 1'b1;

    guard = 0; seen = 1'b0;
    while (!seen && guard < 20000) begin
      @(negedge clk); #1;
      guard++;
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", int'(seen), 1);
    chk("frame_swaps", swaps, WORDS);
    chk("frame_pixels", pix_total, H * V);
    chk("frame_done_count", fd_count, 1);
    chk("b_win_px629", cap_win[629], 0);
    chk("b_win_px630", cap_win[630], 1);
    chk("b_sp_px630", cap_sp[630], 0);
    chk("b_win_px639", cap_win[639], 1);
    chk("b_sp_px639", cap_sp[639], 9);
    chk("b_win_px640", cap_win[640], 0);
    chk("b_sp_px640", cap_sp[640], 0);
    @(negedge clk); #1;
    chk("frame_done_pulse_width", int'(frame_done), 0);
`ifdef MERGE_SEQ_CONT_EN
    chk("cont_busy", int'(busy), 1);
    chk("cont_restart_bg_addr", int'(bg_addr), 0);
`else
    chk("idle_busy", int'(busy), 0);
    chk("idle_bank_full", int'(bank_full), 0);
`endif
    auto_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
